// File: rtl/core_inst_sequencer.sv
// Core instruction sequencer: walks Q/K load, execute, ofifo drain and SFP phases.
// Latency: every output is registered; a state's word is visible right after the edge that enters it.
// Backpressure: hold freezes state, counters and all output registers; reset overrides hold.
module core_inst_sequencer #(
  parameter int TOTAL_CYCLE = 8,
  parameter int COL         = 8,
  parameter int GAP         = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        hold,
  output logic [18:0] inst,
  output logic        data_sel,
  output logic [3:0]  data_idx,
  output logic        busy,
  output logic        done
);

  // One SFP row frame is a fixed number of cycles.
  localparam int SFP_LEN = 10;

  localparam logic [7:0] Q_LAST   = 8'(TOTAL_CYCLE - 1);
  localparam logic [7:0] K_LAST   = 8'(COL - 1);
  localparam logic [7:0] KL_LAST  = 8'(COL);
  localparam logic [7:0] G_LAST   = 8'(GAP - 1);
  localparam logic [7:0] S_LAST   = 8'(SFP_LEN - 1);
  localparam logic [3:0] ROW_LAST = 4'(TOTAL_CYCLE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_KLOAD, S_KTAIL, S_GAP1, S_EXEC,
    S_GAP2, S_OFIFO, S_GAP3, S_SFP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  row_q, row_d;

  logic [18:0] inst_q, inst_d;
  logic        sel_q, sel_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  cnt_m1;

  // Next state and counters; every phase leaves exactly at its terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    if (!hold) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_QWR;
            cnt_d   = '0;
            row_d   = '0;
          end
        end
        S_QWR: begin
          if (cnt_q == Q_LAST) begin state_d = S_KWR; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_KWR: begin
          if (cnt_q == K_LAST) begin state_d = S_KLOAD; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_KLOAD: begin
          if (cnt_q == KL_LAST) begin state_d = S_KTAIL; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_KTAIL: begin
          state_d = S_GAP1;
          cnt_d   = '0;
        end
        S_GAP1: begin
          if (cnt_q == G_LAST) begin state_d = S_EXEC; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_EXEC: begin
          if (cnt_q == Q_LAST) begin state_d = S_GAP2; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_GAP2: begin
          if (cnt_q == G_LAST) begin state_d = S_OFIFO; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_OFIFO: begin
          if (cnt_q == Q_LAST) begin state_d = S_GAP3; cnt_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_GAP3: begin
          if (cnt_q == G_LAST) begin state_d = S_SFP; cnt_d = '0; row_d = '0; end
          else cnt_d = cnt_q + 8'd1;
        end
        S_SFP: begin
          if (cnt_q == S_LAST) begin
            cnt_d = '0;
            if (row_q == ROW_LAST) state_d = S_DONE;
            else row_d = row_q + 4'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          row_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          row_d   = '0;
        end
      endcase
    end
  end

  // Decode the upcoming state/counters into the word registered on this edge.
  always_comb begin
    inst_d = '0;
    sel_d  = 1'b0;
    idx_d  = '0;
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    cnt_m1 = cnt_d - 8'd1;
    unique case (state_d)
      S_QWR: begin
        inst_d[4]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
        idx_d         = cnt_d[3:0];
      end
      S_KWR: begin
        inst_d[2]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
        sel_d         = 1'b1;
        idx_d         = cnt_d[3:0];
      end
      S_KLOAD: begin
        // Read address lags one cycle behind the load pipeline.
        inst_d[6] = 1'b1;
        if (cnt_d >= 8'd1) inst_d[3] = 1'b1;
        if (cnt_d >= 8'd2) inst_d[15:12] = cnt_m1[3:0];
      end
      S_KTAIL: inst_d[6] = 1'b1;
      S_EXEC: begin
        inst_d[7]     = 1'b1;
        inst_d[5]     = 1'b1;
        inst_d[15:12] = cnt_d[3:0];
      end
      S_OFIFO: begin
        inst_d[16]   = 1'b1;
        inst_d[0]    = 1'b1;
        inst_d[11:8] = cnt_d[3:0];
      end
      S_SFP: begin
        inst_d[1]    = 1'b1;
        inst_d[11:8] = row_d;
        if (cnt_d >= 8'd2 && cnt_d <= 8'd4) inst_d[17] = 1'b1;
        if (cnt_d >= 8'd7 && cnt_d <= 8'd9) inst_d[18] = 1'b1;
      end
      S_DONE: done_d = 1'b1;
      default: inst_d = '0;
    endcase
  end

  // State, counter and output registers; reset beats hold, hold freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      inst_q  <= '0;
      sel_q   <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!hold) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      inst_q  <= inst_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst     = inst_q;
  assign data_sel = sel_q;
  assign data_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/core_inst_sequencer.md
CORE_INST_SEQUENCER -- requirements
Module: core_inst_sequencer

Interface
REQ-001 Parameters SHALL be: TOTAL_CYCLE, default 8, number of Q rows processed; COL, default 8, number of K rows (columns); GAP, default 10, idle cycles between phases; SFP_LEN, fixed 10, cycles per SFP row frame.
REQ-002 Legal range SHALL be 1..16 for TOTAL_CYCLE and COL, because addresses are 4 bits; GAP SHALL be 1..255.
REQ-003 The ports SHALL be:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin one full sequence, sampled in IDLE only.
- hold  input  1  stall: freeze state and counters.
- inst  output  19  core instruction word.
- data_sel  output  1  0 = Q row requested, 1 = K row requested.
- data_idx  output  4  row index that upstream must place on mem_in this cycle.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at sequence end.
REQ-004 The inst bit map SHALL be: [18] div_ready, [17] acc_ready, [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.

Function
REQ-005 All outputs SHALL be registered; the word for a state cycle is visible in the cycle after the edge that enters that cycle.
REQ-006 States SHALL run in this order: IDLE, QWR, KWR, KLOAD, KTAIL, GAP1, EXEC, GAP2, OFIFO, GAP3, SFP, DONE, IDLE.
REQ-007 IDLE SHALL drive inst=0; start=1 at an edge moves to QWR, and the first QWR word is visible right after that edge.
REQ-008 QWR SHALL last TOTAL_CYCLE cycles: qmem_wr=1, qkmem_add=i, data_sel=0, data_idx=i, for i=0..TOTAL_CYCLE-1.
REQ-009 KWR SHALL last COL cycles: kmem_wr=1, qkmem_add=i, data_sel=1, data_idx=i.
REQ-010 KLOAD SHALL last COL+1 cycles indexed j=0..COL:
- load=1 in every cycle.
- kmem_rd=1 for j>=1.
- qkmem_add=0 for j<=1, otherwise j-1.
REQ-011 KTAIL SHALL last 1 cycle: load=1, all other bits 0.
REQ-012 GAP1, GAP2 and GAP3 SHALL each last GAP cycles with inst=0.
REQ-013 EXEC SHALL last TOTAL_CYCLE cycles: execute=1, qmem_rd=1, qkmem_add=i.
REQ-014 OFIFO SHALL last TOTAL_CYCLE cycles: ofifo_rd=1, pmem_wr=1, pmem_add=i.
REQ-015 SFP SHALL run TOTAL_CYCLE frames r of SFP_LEN cycles c=0..9:
- pmem_rd=1 and pmem_add=r throughout the frame.
- acc_ready=1 for c=2..4.
- div_ready=1 for c=7..9.
- All other bits 0.
REQ-016 DONE SHALL last 1 cycle: inst=0, done=1; the next state is IDLE.
REQ-017 data_sel and data_idx SHALL be 0 outside QWR/KWR.
REQ-018 busy SHALL be 1 in every state except IDLE, including DONE.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 hold=1 SHALL freeze state, counters and every output register.
- The frozen word repeats, including write strobes, so upstream keeps data stable.
- hold in IDLE SHALL block start.
- hold=1 together with reset=1: reset wins.
REQ-021 Counters SHALL never wrap: each phase exits exactly at its terminal count, so addresses never exceed TOTAL_CYCLE-1 or COL-1.
REQ-022 With defaults, the sequence SHALL be 152 non-IDLE words before DONE: 8+8+9+1+10+8+10+8+10+80.

Reset
REQ-023 reset=1 at an edge SHALL force, from the next cycle: IDLE, inst=0, data_sel=0, data_idx=0, busy=0, done=0, all counters 0.
REQ-024 Reset mid-operation SHALL abort without a done pulse; start is accepted on the first edge with reset=0.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Defaults, start pulse in IDLE -> QWR words 0x00010, 0x01010 .. 0x07010; done=1 exactly 153 cycles after the start edge; busy=1 for those 153 cycles.
- KLOAD check -> words 0x00040, 0x00048, 0x01048 .. 0x07048, then KTAIL 0x00040.
- SFP frame r=3 -> c0 0x00302, c2 0x20302, c7 0x40302; OFIFO i=5 word 0x10501.
- hold=1 for 4 cycles in EXEC at i=2 -> word 0x020A0 repeats 5 cycles in total, and done is delayed by 4 cycles.
- reset=1 during SFP -> inst=0 and busy=0 the next cycle, no done; a fresh start then reproduces the full sequence.
- start held high continuously -> exactly one sequence per IDLE entry; TOTAL_CYCLE=16 -> max qkmem_add 0xF, no wrap.
